// File: rtl/bitserial_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package bitserial_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell built from two half adders and an OR.
// The carry register lives in the parent so this cell stays purely combinational.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic ha0_s;
   logic ha0_c;
   logic ha1_c;

   assign ha0_s = a ^ b;
   assign ha0_c = a & b;

   assign s     = ha0_s ^ cin;
   assign ha1_c = ha0_s & cin;

   assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/bitserial_add_seq.sv
// Bit-serial WIDTH-bit adder: operands accepted over valid/ready, summed LSB-first
// one bit per clock, result presented over valid/ready. Define SERIAL_ADD_SUB_EN for A-B.
module bitserial_add_seq
   import bitserial_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             sum_bit;
   logic             carry_nx;
   logic             sub_eff;
   logic             load_en;
   logic             shift_en;
   logic             last_bit;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_eff = in_sub;
`else
   logic unused_in_sub;
   assign unused_in_sub = in_sub;
   assign sub_eff       = 1'b0;
`endif

   assign last_bit = (cnt == CW'(WIDTH - 1));

   serial_fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (sum_bit),
      .cout (carry_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      load_en   = 1'b0;
      shift_en  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_en  = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            if (last_bit) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // B is stored pre-inverted for subtract, so the latched operation needs no extra flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
      end else if (load_en) begin
         a_sr  <= in_a;
         b_sr  <= sub_eff ? ~in_b : in_b;
         cnt   <= '0;
         carry <= sub_eff;
      end else if (shift_en) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         res   <= {sum_bit, res[WIDTH-1:1]};
         carry <= carry_nx;
         if (!last_bit) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign out_sum  = res;
   assign out_cout = carry;

endmodule

// File: tb/tb_bitserial_add_seq.sv
// Self-checking bench for bitserial_add_seq: directed cases plus randomized traffic
// checked every cycle against a timing/arithmetic model.
module tb_bitserial_add_seq;

   localparam int W = 8;

`ifdef SERIAL_ADD_SUB_EN
   localparam bit          SUB_EN = 1'b1;
   localparam logic [7:0]  E_SUB1 = 8'h02;
   localparam logic        C_SUB1 = 1'b1;
   localparam logic [7:0]  E_SUB2 = 8'hFE;
   localparam logic        C_SUB2 = 1'b0;
`else
   localparam bit          SUB_EN = 1'b0;
   localparam logic [7:0]  E_SUB1 = 8'h08;
   localparam logic        C_SUB1 = 1'b0;
   localparam logic [7:0]  E_SUB2 = 8'h08;
   localparam logic        C_SUB2 = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bitserial_add_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // {cout, sum} of the operation as plain arithmetic.
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
      logic [W:0] r;
      logic [W-1:0] nb;
      nb = ~b;
      if (SUB_EN && sub) r = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
      else               r = {1'b0, a} + {1'b0, b};
      return r;
   endfunction

   // Model: age = edges since accept (-1 when idle); result visible once age reaches W.
   int           age = -1;
   logic [W-1:0] last_sum = '0;
   logic         last_cout = 1'b0;
   logic [W-1:0] pend_sum;
   logic         pend_cout;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", int'(in_ready), int'(age < 0));
         chk("out_valid", int'(out_valid), int'(age >= W));
         chk("busy", int'(busy), int'(age >= 0));
         if (age < 0 || age >= W) begin
            chk("out_sum", int'(out_sum), int'(last_sum));
            chk("out_cout", int'(out_cout), int'(last_cout));
         end
      end
      if (rst) begin
         age       = -1;
         last_sum  = '0;
         last_cout = 1'b0;
      end else if (age < 0) begin
         if (in_valid) begin
            {pend_cout, pend_sum} = ref_op(in_a, in_b, in_sub);
            age = 0;
         end
      end else if (age < W) begin
         age++;
         if (age == W) begin
            last_sum  = pend_sum;
            last_cout = pend_cout;
         end
      end else if (out_ready) begin
         age = -1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 40) begin
         tick();
         k++;
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] exp_s, input logic exp_c, input string nm);
      int k;
      k = 0;
      while (!in_ready && k < 40) begin
         tick();
         k++;
      end
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid(k);
      chk({nm, "_lat"}, k, W);
      chk({nm, "_sum"}, int'(out_sum), int'(exp_s));
      chk({nm, "_cout"}, int'(out_cout), int'(exp_c));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int k;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_sub = 1'b0;
      repeat (2) tick();
      chk_en = 1'b1;
      rst = 1'b0;
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_sum", int'(out_sum), 0);

      run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "add_5_3");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap");
      run_op(8'h05, 8'h03, 1'b1, E_SUB1, C_SUB1, "sub_5_3");
      run_op(8'h03, 8'h05, 1'b1, E_SUB2, C_SUB2, "sub_3_5");

      // Backpressure with a competing request held on the input.
      in_a = 8'h21; in_b = 8'h13; in_sub = 1'b0; in_valid = 1'b1;
      tick();
      in_a = 8'h44; in_b = 8'h11;
      wait_valid(k);
      chk("bp_lat", k, W);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_sum", int'(out_sum), 8'h34);
         chk("bp_ready", int'(in_ready), 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_idle_ready", int'(in_ready), 1);
      chk("bp_idle_valid", int'(out_valid), 0);
      tick();
      chk("bp_accept", int'(busy), 1);
      in_valid = 1'b0;
      wait_valid(k);
      chk("bp2_sum", int'(out_sum), 8'h55);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset in the middle of a shift.
      in_a = 8'h77; in_b = 8'h11; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", int'(in_ready), 1);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_sum", int'(out_sum), 0);
      chk("midrst_busy", int'(busy), 0);
      run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "post_rst");

      // Back-to-back with in_valid and out_ready held high.
      out_ready = 1'b1;
      in_a = 8'h5A; in_b = 8'h33; in_sub = 1'b0; in_valid = 1'b1;
      tick();
      in_a = 8'h0F; in_b = 8'hF0;
      wait_valid(k);
      chk("b2b1_lat", k, W);
      chk("b2b1_sum", int'(out_sum), 8'h8D);
      tick();
      chk("b2b_ready", int'(in_ready), 1);
      tick();
      chk("b2b_accept", int'(busy), 1);
      in_valid = 1'b0;
      wait_valid(k);
      chk("b2b2_lat", k, W);
      chk("b2b2_sum", int'(out_sum), 8'hFF);
      chk("b2b2_cout", int'(out_cout), 0);
      tick();
      out_ready = 1'b0;

      // Randomized traffic, checked by the per-cycle model.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         in_a      = W'($urandom);
         in_b      = W'($urandom);
         in_sub    = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (W + 3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
